// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// The FSM encoding, default depth and word-address shift live here.
package imem_loader_pkg;

    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_SHIFT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Word index to byte address; addresses are always word-aligned.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx << ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// 8-to-32 little-endian shift register: the first byte ends up in [7:0],
// the fourth in [31:24]. word_full flags the shift that completes a word.
module imem_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word;
    logic [1:0]  cnt;

    // New bytes enter at the top so earlier bytes drift down to the low lanes.
    assign word_next = {din, word[31:8]};
    assign word_full = shift_en && (cnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            word <= word_next;
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory,
// one word per write strobe, holding the CPU in reset (busy) meanwhile.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IW = $clog2(DEPTH) + 1;

    state_t        state;
    logic [IW-1:0] word_idx;
    logic [7:0]    len;
    logic          accept;
    logic          pk_clr;
    logic          pk_shift;
    logic [31:0]   pk_next;
    logic          pk_full;
    logic          last_word;

    assign accept    = in_valid && in_ready;
    assign pk_clr    = (state == S_IDLE) && start;
    assign pk_shift  = accept && (state == S_BYTE);
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

    imem_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pk_clr),
        .shift_en  (pk_shift),
        .din       (in_data),
        .word_next (pk_next),
        .word_full (pk_full)
    );

    // Outputs are registered against the state being entered, so each one is
    // a flop that is valid for exactly the cycles the FSM sits in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            word_idx <= '0;
            len      <= '0;
            in_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LEN;
                        word_idx <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        len <= in_data;
                        if (in_data == 8'd0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                        end else if (32'(in_data) > 32'(DEPTH)) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= S_BYTE;
                        end
                    end
                end
                S_BYTE: begin
                    if (pk_full) begin
                        state    <= S_WRITE;
                        in_ready <= 1'b0;
                        we       <= 1'b1;
                        waddr    <= word_addr(32'(word_idx));
                        wdata    <= pk_next;
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (last_word) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_BYTE;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench: each load's expected writes are derived from
// the byte stream alone (word i = bytes 1+4i..4+4i, little-endian, at 4*i).
module tb_imem_loader;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Observation log, sampled mid-cycle.
    int          cyc = 0;
    logic [63:0] obs_q[$];
    int          we_cyc[$];
    int          acc_cyc[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          bad_cnt = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (we) begin
            obs_q.push_back({waddr, wdata});
            we_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if ((!we && (waddr != 0 || wdata != 0)) || (in_ready && !busy) ||
            (done && err) || (we && waddr[1:0] != 2'b00))
            bad_cnt <= bad_cnt + 1;
    end

    logic [7:0] stim[$];
    int         last_bw;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, input bit with_start);
        bit got;
        for (int s = 0; s < stall; s++) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        if (with_start) start = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) begin
            ncmp++;
            nfail++;
            $error("FAIL byte_accept_timeout: observed in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 100 && !idle; t++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) begin
            ncmp++;
            nfail++;
            $error("FAIL %s idle_timeout: observed busy=1 expected 0", tag);
        end
    endtask

    task automatic do_load(input string tag, input int stall_max, input bit start_mid);
        int L, nw, nsend, bw, ba, d0, e0;
        bit ok_exp;
        logic [63:0] exp;
        L      = int'(stim[0]);
        ok_exp = (L <= DEPTH);
        nw     = ok_exp ? L : 0;
        nsend  = ok_exp ? 1 + 4 * L : 1;
        bw = obs_q.size(); ba = acc_cyc.size(); d0 = done_cnt; e0 = err_cnt;
        last_bw = bw;
        pulse_start();
        for (int k = 0; k < nsend; k++)
            send_byte(stim[k], $urandom_range(stall_max, 0), start_mid && k == 3);
        wait_idle(tag);
        check({tag, " nwrites"}, 64'(obs_q.size() - bw), 64'(nw));
        for (int i = 0; i < nw && bw + i < obs_q.size(); i++) begin
            exp = {32'(4 * i), stim[4 + 4 * i], stim[3 + 4 * i], stim[2 + 4 * i], stim[1 + 4 * i]};
            check({tag, " write"}, obs_q[bw + i], exp);
            if (ba + 4 + 4 * i < acc_cyc.size())
                check({tag, " latency"}, 64'(we_cyc[bw + i]), 64'(acc_cyc[ba + 4 + 4 * i] + 1));
        end
        check({tag, " done"}, 64'(done_cnt - d0), 64'(ok_exp ? 1 : 0));
        check({tag, " err"}, 64'(err_cnt - e0), 64'(ok_exp ? 0 : 1));
        check({tag, " busy_low"}, 64'(busy), 64'(0));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " in_ready"}, 64'(in_ready), 64'(0));
        check({tag, " we"}, 64'(we), 64'(0));
        check({tag, " waddr"}, 64'(waddr), 64'(0));
        check({tag, " wdata"}, 64'(wdata), 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
        check({tag, " done"}, 64'(done), 64'(0));
        check({tag, " err"}, 64'(err), 64'(0));
    endtask

    task automatic load_basic();
        stim = '{8'h02, 8'h93, 8'h00, 8'h31, 8'h00, 8'h13, 8'h81, 8'hD2, 8'hFF};
    endtask

    initial begin
        int n0, L;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset busy", 64'(busy), 64'(0));

        // Basic two-word load, with fixed expected words as well
        load_basic();
        do_load("basic", 0, 1'b0);
        if (obs_q.size() >= last_bw + 2) begin
            check("basic word0", obs_q[last_bw], {32'h0, 32'h00310093});
            check("basic word1", obs_q[last_bw + 1], {32'h4, 32'hFFD28113});
        end else begin
            check("basic count", 64'(obs_q.size() - last_bw), 64'(2));
        end

        // Same stream with two idle cycles between every byte
        load_basic();
        do_load("stall2", 2, 1'b0);

        // Header bounds
        stim = '{8'h00};
        do_load("len0", 0, 1'b0);
        stim = '{8'h21};
        do_load("len33", 0, 1'b0);
        stim = '{8'h20};
        for (int k = 0; k < 4 * 32; k++) stim.push_back(8'($urandom));
        do_load("len32", 1, 1'b0);
        if (obs_q.size() > 0)
            check("len32 last_addr", 64'(obs_q[obs_q.size() - 1][63:32]), 64'(32'h7C));

        // start asserted while the FSM is collecting data bytes
        load_basic();
        do_load("start_busy", 1, 1'b1);

        // Reset in the middle of a load
        load_basic();
        pulse_start();
        for (int k = 0; k < 6; k++) send_byte(stim[k], 0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        n0 = obs_q.size();
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midreset no_we", 64'(obs_q.size()), 64'(n0));
        check("midreset idle", 64'(busy), 64'(0));
        load_basic();
        do_load("after_reset", 0, 1'b0);

        // Randomized loads, including over-length headers
        for (int r = 0; r < 8; r++) begin
            L = (r == 5) ? int'($urandom_range(255, DEPTH + 1)) : int'($urandom_range(6, 1));
            stim = '{8'(L)};
            if (L <= DEPTH)
                for (int k = 0; k < 4 * L; k++) stim.push_back(8'($urandom));
            do_load("random", 3, r[0]);
        end

        repeat (3) @(negedge clk);
        check("output_invariants", 64'(bad_cnt), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
